wb_arbiter_2: RTL



---
 rtl/wb_arbiter_2_pkg.sv | 13 +
 rtl/wb_arbiter_2_arbiter.sv | 79 +++++++
 rtl/wb_arbiter_2.sv | 93 +++++++++
 3 files changed

// File: rtl/wb_arbiter_2_pkg.sv
// Shared constants and helpers for the two-master Wishbone arbiter and its
// reusable arbitration core.
package wb_arbiter_2_pkg;

    localparam int    ARB_FIXED_PRIORITY = 0;
    localparam int    ARB_ROUND_ROBIN    = 1;
    localparam string ARB_BLOCK_REQUEST  = "REQUEST";

    function automatic logic gate_resp(input logic owned, input logic resp);
        return owned & resp;
    endfunction

endpackage

// File: rtl/wb_arbiter_2_arbiter.sv
// Generic N-port request arbiter: fixed priority or round robin, with the
// grant held for as long as the granted port keeps requesting.
module arbiter
    import wb_arbiter_2_pkg::*;
#(
    parameter int    PORTS             = 2,
    parameter int    TYPE_ROUND_ROBIN  = ARB_FIXED_PRIORITY,
    parameter int    LSB_HIGH_PRIORITY = 1,
    parameter string BLOCK             = ARB_BLOCK_REQUEST,
    localparam int   IW                = (PORTS > 1) ? $clog2(PORTS) : 1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] i_request,
    output logic             o_grant_valid,
    output logic [IW-1:0]    o_grant_index,
    output logic [PORTS-1:0] o_grant
);

    logic          r_grant_valid;
    logic [IW-1:0] r_grant_index;
    logic [IW-1:0] r_last_index;
    logic          w_hold;
    logic          w_any;
    logic [IW-1:0] w_winner;

    // Only the request-blocking policy holds a grant; anything else re-arbitrates every cycle.
    assign w_hold = (BLOCK == ARB_BLOCK_REQUEST) && r_grant_valid && i_request[r_grant_index];
    assign w_any  = |i_request;

    always_comb begin
        logic [IW-1:0] cand;
        w_winner = '0;
        cand     = '0;
        if (TYPE_ROUND_ROBIN != 0) begin
            // Walk backwards so the port closest after last_index is assigned last and wins.
            for (int k = PORTS; k >= 1; k--) begin
                cand = IW'((int'(r_last_index) + k) % PORTS);
                if (i_request[cand]) begin
                    w_winner = cand;
                end
            end
        end else if (LSB_HIGH_PRIORITY != 0) begin
            for (int i = PORTS - 1; i >= 0; i--) begin
                if (i_request[IW'(i)]) begin
                    w_winner = IW'(i);
                end
            end
        end else begin
            for (int i = 0; i < PORTS; i++) begin
                if (i_request[IW'(i)]) begin
                    w_winner = IW'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_valid <= 1'b0;
            r_grant_index <= '0;
            r_last_index  <= IW'(PORTS - 1);
        end else if (!w_hold) begin
            r_grant_valid <= w_any;
            r_grant_index <= w_winner;
            if (w_any) begin
                r_last_index <= w_winner;
            end
        end
    end

    assign o_grant_valid = r_grant_valid;
    assign o_grant_index = r_grant_index;

    for (genvar gi = 0; gi < PORTS; gi++) begin : g_onehot
        assign o_grant[gi] = r_grant_valid && (r_grant_index == IW'(gi));
    end

endmodule

// File: rtl/wb_arbiter_2.sv
// Two-master to one-slave Wishbone arbiter: request muxing and response
// gating around the shared arbitration core.
module wb_arbiter_2
    import wb_arbiter_2_pkg::*;
#(
    parameter int DATA_WIDTH            = 32,
    parameter int ADDR_WIDTH            = 32,
    parameter int SELECT_WIDTH          = DATA_WIDTH / 8,
    parameter int ARB_TYPE_ROUND_ROBIN  = ARB_FIXED_PRIORITY,
    parameter int ARB_LSB_HIGH_PRIORITY = 1
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
    input  logic                    wbm0_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm0_sel_i,
    input  logic                    wbm0_stb_i,
    output logic                    wbm0_ack_o,
    output logic                    wbm0_err_o,
    output logic                    wbm0_rty_o,
    input  logic                    wbm0_cyc_i,
    input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
    input  logic                    wbm1_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm1_sel_i,
    input  logic                    wbm1_stb_i,
    output logic                    wbm1_ack_o,
    output logic                    wbm1_err_o,
    output logic                    wbm1_rty_o,
    input  logic                    wbm1_cyc_i,
    output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
    input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
    output logic [DATA_WIDTH-1:0]   wbs_dat_o,
    output logic                    wbs_we_o,
    output logic [SELECT_WIDTH-1:0] wbs_sel_o,
    output logic                    wbs_stb_o,
    input  logic                    wbs_ack_i,
    input  logic                    wbs_err_i,
    input  logic                    wbs_rty_i,
    output logic                    wbs_cyc_o
);

    logic [1:0] w_request;
    logic [1:0] w_grant;
    logic       w_grant_valid;
    logic       w_grant_index;
    logic       w_sel_m1;
    logic       w_own0;
    logic       w_own1;

    assign w_request = {wbm1_cyc_i, wbm0_cyc_i};

    arbiter #(
        .PORTS             (2),
        .TYPE_ROUND_ROBIN  (ARB_TYPE_ROUND_ROBIN),
        .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY),
        .BLOCK             (ARB_BLOCK_REQUEST)
    ) u_arbiter (
        .clk           (clk),
        .rst           (rst),
        .i_request     (w_request),
        .o_grant_valid (w_grant_valid),
        .o_grant_index (w_grant_index),
        .o_grant       (w_grant)
    );

    // Master 0 drives the slave bus whenever master 1 does not own it, including idle.
    assign w_sel_m1 = w_grant_valid && w_grant_index;
    assign w_own0   = w_grant[0] && wbm0_cyc_i;
    assign w_own1   = w_grant[1] && wbm1_cyc_i;

    assign wbs_adr_o = w_sel_m1 ? wbm1_adr_i : wbm0_adr_i;
    assign wbs_dat_o = w_sel_m1 ? wbm1_dat_i : wbm0_dat_i;
    assign wbs_we_o  = w_sel_m1 ? wbm1_we_i  : wbm0_we_i;
    assign wbs_sel_o = w_sel_m1 ? wbm1_sel_i : wbm0_sel_i;
    assign wbs_cyc_o = w_own0 || w_own1;
    assign wbs_stb_o = (w_own0 && wbm0_stb_i) || (w_own1 && wbm1_stb_i);

    // Responses reach only the owning master; anything while the bus is idle is dropped.
    assign wbm0_ack_o = gate_resp(w_own0, wbs_ack_i);
    assign wbm0_err_o = gate_resp(w_own0, wbs_err_i);
    assign wbm0_rty_o = gate_resp(w_own0, wbs_rty_i);
    assign wbm1_ack_o = gate_resp(w_own1, wbs_ack_i);
    assign wbm1_err_o = gate_resp(w_own1, wbs_err_i);
    assign wbm1_rty_o = gate_resp(w_own1, wbs_rty_i);

    assign wbm0_dat_o = wbs_dat_i;
    assign wbm1_dat_o = wbs_dat_i;

endmodule
